// File: rtl/ghostbus_host.sv
// ghostbus_host: bus initiator for a ghostbus-decoded design.
// Turns a valid/ready request stream into single-beat writes or
// auto-incrementing read bursts and returns read data on a
// valid/ready response stream. At most one read beat is outstanding.
module ghostbus_host #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 2,
    parameter int LW         = 8
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [LW-1:0] req_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_last,
    output logic          busy,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    input  logic [DW-1:0] gb_rdata,
    output logic          gb_wen,
    output logic          gb_rstb
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD
    } state_t;

    // Latency counter preload: the strobe cycle itself counts as the first
    // cycle, so data is sampled when the counter reaches zero.
    localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY - 1);

    state_t        state;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len_reg;
    logic [LW-1:0] beat_cnt;
    logic [3:0]    lat_cnt;
    logic [AW-1:0] next_addr;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Address of the following beat; wraps silently modulo 2^AW.
    always_comb begin
        next_addr = base_addr + AW'(beat_cnt) + AW'(1);
    end

    // Main controller: strobes are raised on the edge entering WRITE or
    // RD_ISSUE so they are high for exactly the cycle spent in that state.
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            state     <= IDLE;
            base_addr <= '0;
            len_reg   <= '0;
            beat_cnt  <= '0;
            lat_cnt   <= '0;
            gb_addr   <= '0;
            gb_wdata  <= '0;
            gb_wen    <= 1'b0;
            gb_rstb   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        gb_addr <= req_addr;
                        if (req_write) begin
                            gb_wdata <= req_wdata;
                            gb_wen   <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            base_addr <= req_addr;
                            len_reg   <= req_len;
                            beat_cnt  <= '0;
                            gb_rstb   <= 1'b1;
                            state     <= RD_ISSUE;
                        end
                    end
                end
                WRITE: begin
                    gb_wen <= 1'b0;
                    state  <= IDLE;
                end
                RD_ISSUE: begin
                    gb_rstb <= 1'b0;
                    lat_cnt <= LAT_LOAD;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        rsp_rdata <= gb_rdata;
                        rsp_valid <= 1'b1;
                        rsp_last  <= (beat_cnt == len_reg);
                        state     <= RD_HOLD;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RD_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (rsp_last) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + LW'(1);
                            gb_addr  <= next_addr;
                            gb_rstb  <= 1'b1;
                            state    <= RD_ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ghostbus_host.sv
// tb_ghostbus_host: directed, table-driven bench for ghostbus_host.
// A small bus memory returns 0xB0+addr exactly RD_LATENCY cycles after
// each read strobe; a monitor logs strobes and response handshakes.
module tb_ghostbus_host;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          gb_clk = 1'b0;
    logic          gb_rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [LW-1:0] req_len = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_last;
    logic          busy;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata;
    logic [DW-1:0] gb_rdata;
    logic          gb_wen;
    logic          gb_rstb;

    ghostbus_host #(.AW(AW), .DW(DW), .RD_LATENCY(2), .LW(LW)) dut (
        .gb_clk(gb_clk), .gb_rst(gb_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_last(rsp_last), .busy(busy),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_rdata(gb_rdata),
        .gb_wen(gb_wen), .gb_rstb(gb_rstb)
    );

    always #5 gb_clk = ~gb_clk;

    int tests = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge gb_clk) cyc = cyc + 1;

    // Bus memory: two-stage pipeline so data is valid only in cycle C+2
    logic          s1_v = 1'b0, s2_v = 1'b0;
    logic [AW-1:0] s1_a = '0, s2_a = '0;
    always @(posedge gb_clk) begin
        s1_v <= gb_rstb;
        s1_a <= gb_addr;
        s2_v <= s1_v;
        s2_a <= s1_a;
    end
    assign gb_rdata = s2_v ? (32'h000000B0 + {8'h00, s2_a}) : 32'hDEADBEEF;

    // Monitor logs
    logic [AW-1:0] wen_addr_q[$];
    logic [DW-1:0] wen_data_q[$];
    int            wen_cyc_q[$];
    logic [AW-1:0] rstb_addr_q[$];
    int            rstb_cyc_q[$];
    int            rise_cyc_q[$];
    logic [DW-1:0] rsp_data_q[$];
    logic          rsp_last_q[$];
    logic          prev_valid = 1'b0;
    logic          overlap_seen = 1'b0;

    always @(negedge gb_clk) begin
        if (gb_wen) begin
            wen_addr_q.push_back(gb_addr);
            wen_data_q.push_back(gb_wdata);
            wen_cyc_q.push_back(cyc);
        end
        if (gb_rstb) begin
            rstb_addr_q.push_back(gb_addr);
            rstb_cyc_q.push_back(cyc);
        end
        if (gb_wen && gb_rstb) overlap_seen = 1'b1;
        if (rsp_valid && !prev_valid) rise_cyc_q.push_back(cyc);
        prev_valid = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            rsp_data_q.push_back(rsp_rdata);
            rsp_last_q.push_back(rsp_last);
        end
    end

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [LW-1:0] len;
        logic [DW-1:0] exp_first_data;
        logic [AW-1:0] exp_last_addr;
        logic [DW-1:0] exp_last_data;
        int            exp_beats;
    } vec_t;

    vec_t tbl[6];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearLogs();
        wen_addr_q.delete(); wen_data_q.delete(); wen_cyc_q.delete();
        rstb_addr_q.delete(); rstb_cyc_q.delete(); rise_cyc_q.delete();
        rsp_data_q.delete(); rsp_last_q.delete();
    endtask

    // Present one request and return the cycle in which it was accepted
    task automatic applyStimulus(input vec_t v, output int acc);
        bit ok = 0;
        acc = -1;
        @(posedge gb_clk); #1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_len   = v.len;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge gb_clk);
            if (req_ready) begin
                acc = cyc;
                ok = 1;
                break;
            end
        end
        if (!ok) checkOutput("accept_timeout", 1, 0);
        @(posedge gb_clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic waitIdle(input int max_cycles);
        bit ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge gb_clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) checkOutput("idle_timeout", 1, 0);
    endtask

    task automatic checkVector(input vec_t v, input int acc);
        int nlast = 0;
        if (v.wr) begin
            checkOutput("wen_count", wen_addr_q.size(), 1);
            if (wen_addr_q.size() > 0) begin
                checkOutput("wen_addr", wen_addr_q[0], v.addr);
                checkOutput("wen_data", wen_data_q[0], v.wdata);
                checkOutput("wen_cycle", wen_cyc_q[0], acc + 1);
            end
            checkOutput("write_rstb_count", rstb_addr_q.size(), 0);
            checkOutput("write_rsp_count", rsp_data_q.size(), 0);
        end else begin
            checkOutput("rstb_count", rstb_addr_q.size(), v.exp_beats);
            checkOutput("rsp_count", rsp_data_q.size(), v.exp_beats);
            checkOutput("read_wen_count", wen_addr_q.size(), 0);
            if (rstb_addr_q.size() > 0) begin
                checkOutput("rstb_first_addr", rstb_addr_q[0], v.addr);
                checkOutput("rstb_last_addr", rstb_addr_q[$], v.exp_last_addr);
                checkOutput("rstb_first_cycle", rstb_cyc_q[0], acc + 1);
            end
            if (rise_cyc_q.size() > 0)
                checkOutput("rsp_first_cycle", rise_cyc_q[0], acc + 4);
            if (rsp_data_q.size() > 0) begin
                checkOutput("rsp_first_data", rsp_data_q[0], v.exp_first_data);
                checkOutput("rsp_last_data", rsp_data_q[$], v.exp_last_data);
                checkOutput("rsp_last_flag", rsp_last_q[$], 1);
                foreach (rsp_last_q[i]) if (rsp_last_q[i]) nlast++;
                checkOutput("rsp_last_count", nlast, 1);
            end
        end
    endtask

    initial begin
        int   acc;
        int   hs;
        bit   stable_ok;
        int   stall_rstb;
        vec_t v;

        tbl[0] = '{wr:1'b1, addr:24'h000001, wdata:32'h0000000E, len:8'd0,
                   exp_first_data:32'h0, exp_last_addr:24'h0, exp_last_data:32'h0, exp_beats:0};
        tbl[1] = '{wr:1'b0, addr:24'h000008, wdata:32'h0, len:8'd0,
                   exp_first_data:32'h000000B8, exp_last_addr:24'h000008, exp_last_data:32'h000000B8, exp_beats:1};
        tbl[2] = '{wr:1'b0, addr:24'h000020, wdata:32'h0, len:8'd3,
                   exp_first_data:32'h000000D0, exp_last_addr:24'h000023, exp_last_data:32'h000000D3, exp_beats:4};
        tbl[3] = '{wr:1'b0, addr:24'hFFFFFF, wdata:32'h0, len:8'd1,
                   exp_first_data:32'h010000AF, exp_last_addr:24'h000000, exp_last_data:32'h000000B0, exp_beats:2};
        tbl[4] = '{wr:1'b1, addr:24'h123456, wdata:32'hCAFEF00D, len:8'd5,
                   exp_first_data:32'h0, exp_last_addr:24'h0, exp_last_data:32'h0, exp_beats:0};
        tbl[5] = '{wr:1'b0, addr:24'h000100, wdata:32'h55555555, len:8'd0,
                   exp_first_data:32'h000001B0, exp_last_addr:24'h000100, exp_last_data:32'h000001B0, exp_beats:1};

        // Reset state
        repeat (3) @(negedge gb_clk);
        checkOutput("reset_bus", {gb_addr, gb_wdata, gb_wen, gb_rstb}, 0);
        checkOutput("reset_rsp", {rsp_rdata, rsp_valid, rsp_last, busy}, 0);
        checkOutput("reset_req_ready", req_ready, 1);
        #1 gb_rst = 1'b0;

        // Table-driven transactions with rsp_ready held high
        for (int i = 0; i < 6; i++) begin
            clearLogs();
            applyStimulus(tbl[i], acc);
            waitIdle(100);
            checkVector(tbl[i], acc);
        end

        // Backpressure: 5 cycles of rsp_ready low on beat 0 of a 2-beat read
        clearLogs();
        rsp_ready = 1'b0;
        v = '{wr:1'b0, addr:24'h000040, wdata:32'h0, len:8'd1,
              exp_first_data:32'h000000F0, exp_last_addr:24'h000041, exp_last_data:32'h000000F1, exp_beats:2};
        applyStimulus(v, acc);
        stable_ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge gb_clk);
            if (rsp_valid) begin
                stable_ok = 1;
                break;
            end
        end
        checkOutput("bp_valid_seen", stable_ok, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge gb_clk);
            if (!(rsp_valid && rsp_rdata == 32'h000000F0 && !rsp_last)) stable_ok = 0;
        end
        stall_rstb = rstb_addr_q.size();
        checkOutput("bp_hold_stable", stable_ok, 1);
        checkOutput("bp_no_early_rstb", stall_rstb, 1);
        @(posedge gb_clk); #1;
        rsp_ready = 1'b1;
        hs = cyc;
        waitIdle(100);
        checkOutput("bp_rsp_count", rsp_data_q.size(), 2);
        checkOutput("bp_rstb_count", rstb_addr_q.size(), 2);
        if (rstb_cyc_q.size() > 1) begin
            checkOutput("bp_second_rstb_cycle", rstb_cyc_q[1], hs + 1);
            checkOutput("bp_second_rstb_addr", rstb_addr_q[1], 24'h000041);
        end
        if (rsp_data_q.size() > 1) begin
            checkOutput("bp_data0", rsp_data_q[0], 32'h000000F0);
            checkOutput("bp_data1", rsp_data_q[1], 32'h000000F1);
            checkOutput("bp_lasts", {rsp_last_q[0], rsp_last_q[1]}, 2'b01);
        end

        // Reset while waiting for read data
        clearLogs();
        v = '{wr:1'b0, addr:24'h000080, wdata:32'h0, len:8'd0,
              exp_first_data:32'h00000130, exp_last_addr:24'h000080, exp_last_data:32'h00000130, exp_beats:1};
        applyStimulus(v, acc);
        @(negedge gb_clk);
        @(negedge gb_clk);
        #1 gb_rst = 1'b1;
        #1;
        checkOutput("rst_async_bus", {gb_addr, gb_wdata, gb_wen, gb_rstb}, 0);
        checkOutput("rst_async_rsp", {rsp_rdata, rsp_valid, rsp_last, busy}, 0);
        repeat (2) @(posedge gb_clk);
        @(negedge gb_clk); #1 gb_rst = 1'b0;
        repeat (8) @(negedge gb_clk);
        checkOutput("rst_no_response", rsp_data_q.size() + rise_cyc_q.size(), 0);
        checkOutput("rst_no_residual_rstb", rstb_addr_q.size(), 1);
        clearLogs();
        v = '{wr:1'b1, addr:24'h000004, wdata:32'h00000044, len:8'd0,
              exp_first_data:32'h0, exp_last_addr:24'h0, exp_last_data:32'h0, exp_beats:0};
        applyStimulus(v, acc);
        waitIdle(100);
        checkVector(v, acc);

        checkOutput("no_wen_rstb_overlap", overlap_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/ghostbus_host.md
Name: ghostbus_host

Overview:
- Bus initiator that drives the ghostbus host port (gb_addr/gb_wdata/gb_wen/gb_rstb, sampling gb_rdata) of a ghostbus-decoded top module.
- Converts a valid/ready request stream into single-beat writes or auto-incrementing read bursts.
- Returns read data on a valid/ready response stream.
- Sits between a host transport (UART/Ethernet bridge, test sequencer) and the generated bus decoder.

Parameters:
- AW, 24, bus address width.
- DW, 32, bus data width.
- RD_LATENCY, 2, cycles from the gb_rstb cycle to valid gb_rdata; legal 1..15.
- LW, 8, width of burst length field.

Ports:
- gb_clk  input  1  bus clock; all logic on rising edge.
- gb_rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when valid&ready.
- req_write  input  1  1=write, 0=read.
- req_addr  input  AW  start address.
- req_wdata  input  DW  write data; ignored for reads.
- req_len  input  LW  read beats minus 1; ignored for writes.
- rsp_valid  output  1  read data present.
- rsp_ready  input  1  response consumed when valid&ready.
- rsp_rdata  output  DW  captured read data.
- rsp_last  output  1  final beat of a burst.
- busy  output  1  state != IDLE.
- gb_addr  output  AW  bus address.
- gb_wdata  output  DW  bus write data.
- gb_rdata  input  DW  bus read data.
- gb_wen  output  1  write enable/strobe, one cycle per write.
- gb_rstb  output  1  read strobe, one cycle per beat.

Behaviour:
- All bus and response outputs are registered.
- Reset (async, immediate) values:
  - state=IDLE.
  - gb_addr=0, gb_wdata=0, gb_wen=0, gb_rstb=0.
  - rsp_valid=0, rsp_rdata=0, rsp_last=0.
  - beat counter=0, latency counter=0.
- req_ready = (state==IDLE), decoded combinationally from state.
- States:
  - IDLE -> WRITE on accepted write; latch addr/wdata.
  - IDLE -> RD_ISSUE on accepted read; latch base addr, len; beat=0.
  - WRITE: gb_wen=1 for exactly one cycle, with gb_addr=req_addr and gb_wdata=req_wdata; -> IDLE. No response generated. Throughput is one write per 2 cycles.
  - RD_ISSUE: gb_rstb=1 for one cycle, gb_addr=(base+beat) mod 2^AW; load latency counter=RD_LATENCY-1; -> RD_WAIT.
  - RD_WAIT:
    - If the counter is 0: sample gb_rdata into rsp_rdata on this edge and set rsp_valid=1.
    - rsp_last=1 if beat==len.
    - Then -> RD_HOLD; otherwise decrement.
  - Sampling point: gb_rstb is high in cycle C; gb_rdata is captured at the edge ending cycle C+RD_LATENCY; rsp_valid is high from cycle C+RD_LATENCY+1.
  - RD_HOLD: rsp_valid, rsp_rdata and rsp_last are held stable until rsp_ready. On handshake, rsp_valid and rsp_last clear, and:
    - if rsp_last -> IDLE;
    - else beat+1 -> RD_ISSUE.
  - No new rstb is issued while a response is pending; at most one beat is outstanding.
- gb_addr and gb_wdata retain their last driven values between transactions. gb_wen and gb_rstb are never high together.
- Address wrap: the increment wraps modulo 2^AW with no error.
- Burst lengths: req_len=0 gives a single beat; req_len=2^LW-1 gives 2^LW beats.
- Reset mid-operation: the transaction is aborted immediately, with no response and no residual strobe. After deassertion the block accepts a new request in IDLE.
- req_valid while busy: held off via req_ready=0; the requester must hold its fields stable.

Test Plan:
- Write addr=0x000001, wdata=0x0000000E:
  - gb_wen high exactly one cycle, one cycle after accept, with gb_addr=0x000001, gb_wdata=0xE.
  - gb_rstb stays 0; no rsp_valid.
- Single read (RD_LATENCY=2) at 0x000008 against a bench memory returning 0xB0+addr:
  - gb_rstb high one cycle.
  - rsp_valid 3 cycles later with rsp_rdata=0xB8 and rsp_last=1.
- Burst read at 0x000020 with req_len=3 and rsp_ready tied 1:
  - gb_rstb addresses 0x20, 0x21, 0x22, 0x23.
  - Four responses in order; rsp_last on the 4th only.
  - busy drops after the last handshake.
- Backpressure: rsp_ready held low 5 cycles on beat 0 of a 2-beat read:
  - rsp_rdata stable and rsp_valid high throughout.
  - No second gb_rstb until the cycle after the handshake.
- Wrap: read at 0xFFFFFF with req_len=1 -> second gb_rstb at gb_addr=0x000000.
- Reset in RD_WAIT:
  - gb_rst pulsed -> all outputs 0 asynchronously and no response emitted.
  - A subsequent write to 0x000004 completes normally.
